// File: rtl/coin_pkg.sv
// Shared definitions for the falling-coin lane: FSM encoding, sprite size, palette.
package coin_pkg;

  localparam int SPRITE_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALL    = 2'd1,
    ST_RESPAWN = 2'd2
  } coin_state_e;

  localparam logic [23:0] PAL_0 = 24'h000000;
  localparam logic [23:0] PAL_1 = 24'hFFDB00;
  localparam logic [23:0] PAL_2 = 24'hFFF2A5;

  function automatic logic [23:0] pal_rgb(input logic [1:0] idx);
    case (idx)
      2'd1:    return PAL_1;
      2'd2:    return PAL_2;
      default: return PAL_0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_coin_rom.sv
// 32x32 coin bitmap: gold rim around a pale face, transparent outside the disc.
module sprite_coin_rom (
  input  logic [4:0] x_i,
  input  logic [4:0] y_i,
  output logic [1:0] idx_o
);

  logic signed [15:0] dx, dy, r2;

  // Distances in half-pixel units from the sprite centre (15.5, 15.5).
  always_comb begin
    dx = $signed({10'd0, x_i, 1'b0}) - 16'sd31;
    dy = $signed({10'd0, y_i, 1'b0}) - 16'sd31;
    r2 = dx * dx + dy * dy;
    if (r2 > 16'sd900)      idx_o = 2'd0;
    else if (r2 > 16'sd484) idx_o = 2'd1;
    else                    idx_o = 2'd2;
  end

endmodule

// File: rtl/sprite_coin_lane.sv
// Single coin falling down a fixed lane, growing 1x/2x/4x with depth; pixel
// outputs are registered one clock behind the raster position.
module sprite_coin_lane
  import coin_pkg::*;
#(
  parameter int LANE_X         = 640,
  parameter int Y_START        = 0,
  parameter int Y_END          = 592,
  parameter int Y_SCALE2       = 300,
  parameter int Y_SCALE4       = 450,
  parameter int SPEED          = 1,
  parameter int RESPAWN_FRAMES = 1000,
  parameter int HIT_Y_MIN      = 144
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_v_sync,
  input  logic        i_enable,
  input  logic        i_collect,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_visible,
  output logic        o_sprite_hit,
  output logic        o_missed,
  output logic        o_active
);

  localparam int CW = $clog2(RESPAWN_FRAMES) + 1;

  coin_state_e   state_q, state_d;
  logic [15:0]   sprite_y_q, sprite_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vs_q, tick, missed_d;
  logic [16:0]   y_sum;

  assign tick  = i_v_sync & ~vs_q;
  assign y_sum = {1'b0, sprite_y_q} + 17'(SPEED);

  always_comb begin
    state_d    = state_q;
    sprite_y_d = sprite_y_q;
    cnt_d      = cnt_q;
    missed_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (tick && i_enable) begin
        state_d    = ST_FALL;
        sprite_y_d = 16'(Y_START);
      end
      ST_FALL: begin
        if (i_collect) begin
          state_d = ST_RESPAWN;
        end else if (tick && i_enable) begin
          if (y_sum >= 17'(Y_END)) begin
            sprite_y_d = 16'(Y_END);
            state_d    = ST_RESPAWN;
            missed_d   = 1'b1;
          end else begin
            sprite_y_d = y_sum[15:0];
          end
        end
      end
      ST_RESPAWN: if (tick) begin
        if (cnt_q == CW'(RESPAWN_FRAMES - 1)) begin
          cnt_d      = '0;
          sprite_y_d = 16'(Y_START);
          state_d    = i_enable ? ST_FALL : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [1:0]  shift;
  logic [16:0] px, py, yb, sx, sz;
  logic        in_box, vis_d, hit_d;
  logic [4:0]  rom_x, rom_y;
  logic [1:0]  idx;

  always_comb begin
    if (sprite_y_q < 16'(Y_SCALE2))      shift = 2'd0;
    else if (sprite_y_q < 16'(Y_SCALE4)) shift = 2'd1;
    else                                 shift = 2'd2;
  end

  // 17-bit compares so a pixel left of / above the box never wraps into it.
  assign px     = {1'b0, i_x};
  assign py     = {1'b0, i_y};
  assign yb     = {1'b0, sprite_y_q};
  assign sz     = 17'(SPRITE_SIZE) << shift;
  assign sx     = 17'(LANE_X) - (sz >> 1);
  assign in_box = (px >= sx) && (px < sx + sz) && (py >= yb) && (py < yb + sz);
  assign rom_x  = 5'((px - sx) >> shift);
  assign rom_y  = 5'((py - yb) >> shift);

  sprite_coin_rom u_rom (
    .x_i   (rom_x),
    .y_i   (rom_y),
    .idx_o (idx)
  );

  assign vis_d = (state_q == ST_FALL) && in_box && (idx != 2'd0);
  assign hit_d = vis_d && (sprite_y_q >= 16'(HIT_Y_MIN)) && (sprite_y_q < 16'(Y_END));

  logic [23:0] rgb_q;
  logic        vis_q, hit_q, missed_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      sprite_y_q <= 16'(Y_START);
      cnt_q      <= '0;
      vs_q       <= 1'b0;
      rgb_q      <= '0;
      vis_q      <= 1'b0;
      hit_q      <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sprite_y_q <= sprite_y_d;
      cnt_q      <= cnt_d;
      vs_q       <= i_v_sync;
      rgb_q      <= vis_d ? pal_rgb(idx) : 24'h0;
      vis_q      <= vis_d;
      hit_q      <= hit_d;
      missed_q   <= missed_d;
    end
  end

  assign o_red        = rgb_q[23:16];
  assign o_green      = rgb_q[15:8];
  assign o_blue       = rgb_q[7:0];
  assign o_visible    = vis_q;
  assign o_sprite_hit = hit_q;
  assign o_missed     = missed_q;
  assign o_active     = (state_q == ST_FALL);

endmodule

// File: tb/tb_sprite_coin_lane.sv
// Directed + randomized bench for sprite_coin_lane against a frame-level model.
module tb_sprite_coin_lane;

  localparam int LANE_X = 640, Y_START = 0, Y_END = 592, Y_SCALE2 = 300;
  localparam int Y_SCALE4 = 450, SPEED = 1, RESP = 4, HIT_Y_MIN = 144;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] i_x = '0, i_y = '0;
  logic        vsync = 1'b0, en = 1'b0, col = 1'b0;
  logic [7:0]  o_red, o_green, o_blue;
  logic        o_visible, o_hit, o_missed, o_active;

  int checks = 0, errors = 0;
  int m_state = 0, m_y = Y_START, m_cnt = 0;
  bit m_missed = 1'b0;

  always #5 clk = ~clk;

  sprite_coin_lane #(
    .LANE_X(LANE_X), .Y_START(Y_START), .Y_END(Y_END), .Y_SCALE2(Y_SCALE2),
    .Y_SCALE4(Y_SCALE4), .SPEED(SPEED), .RESPAWN_FRAMES(RESP), .HIT_Y_MIN(HIT_Y_MIN)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_x(i_x), .i_y(i_y), .i_v_sync(vsync),
    .i_enable(en), .i_collect(col), .o_red(o_red), .o_green(o_green),
    .o_blue(o_blue), .o_visible(o_visible), .o_sprite_hit(o_hit),
    .o_missed(o_missed), .o_active(o_active)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: state 0 = hidden/idle, 1 = falling, 2 = waiting to respawn.
  task automatic mdl_step(input bit tk, input bit c, input bit e);
    m_missed = 1'b0;
    if (c && m_state == 1) begin
      m_state = 2;
    end else if (tk) begin
      if (m_state == 0) begin
        if (e) begin m_state = 1; m_y = Y_START; end
      end else if (m_state == 1) begin
        if (e) begin
          m_y = (m_y + SPEED > Y_END) ? Y_END : m_y + SPEED;
          if (m_y == Y_END) begin m_state = 2; m_missed = 1'b1; end
        end
      end else begin
        if (m_cnt == RESP - 1) begin
          m_cnt = 0; m_y = Y_START; m_state = e ? 1 : 0;
        end else m_cnt++;
      end
    end
  endtask

  function automatic logic [25:0] exp_pix(input int x, input int y);
    int s, sx, u, v, dx, dy, r2;
    logic [23:0] rgb;
    if (m_state != 1) return '0;
    s  = (m_y < Y_SCALE2) ? 1 : (m_y < Y_SCALE4) ? 2 : 4;
    sx = LANE_X - 16 * s;
    if (x < sx || x >= sx + 32 * s || y < m_y || y >= m_y + 32 * s) return '0;
    u  = (x - sx) / s;
    v  = (y - m_y) / s;
    dx = 2 * u - 31;
    dy = 2 * v - 31;
    r2 = dx * dx + dy * dy;
    if (r2 > 900) return '0;
    rgb = (r2 > 484) ? 24'hFFDB00 : 24'hFFF2A5;
    return {rgb, 1'b1, (m_y >= HIT_Y_MIN && m_y < Y_END)};
  endfunction

  task automatic frame(input bit e, input bit vs, input bit c);
    en = e; vsync = vs; col = c;
    @(posedge clk); #1;
    vsync = 1'b0; col = 1'b0;
    mdl_step(vs, c, e);
    chk("active", o_active, m_state == 1);
    chk("missed_edge", o_missed, m_missed);
    chk("sprite_y", dut.sprite_y_q, 16'(m_y));
    @(posedge clk); #1;
    chk("missed_clear", o_missed, 1'b0);
  endtask

  task automatic probe(input string tag, input int x, input int y);
    i_x = 16'(x); i_y = 16'(y);
    @(posedge clk); #1;
    chk(tag, {o_red, o_green, o_blue, o_visible, o_hit}, exp_pix(x, y));
  endtask

  task automatic rand_probes();
    for (int k = 0; k < 2; k++) begin
      int x = LANE_X + int'($urandom_range(0, 150)) - 75;
      int y = m_y + int'($urandom_range(0, 140)) - 4;
      probe("rand_pix", x, (y < 0) ? 0 : y);
    end
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 3000 && !(m_state == 1 && m_y == target); g++) begin
      frame($urandom_range(0, 7) != 0, 1'b1, 1'b0);
      rand_probes();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", {o_red, o_green, o_blue}, 24'h0);
    chk("rst_vis_hit_miss", {o_visible, o_hit, o_missed}, 3'b000);
    chk("rst_active", o_active, 1'b0);
    chk("rst_y", dut.sprite_y_q, 16'(Y_START));
    rst = 1'b0;

    frame(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b1, 1'b0);
    chk("spawn_y2", dut.sprite_y_q, 16'd2);
    probe("rim_pixel", LANE_X - 16 + 12, m_y + 5);
    chk("rim_rgb", {o_red, o_green, o_blue, o_visible}, {24'hFFDB00, 1'b1});
    frame(1'b1, 1'b0, 1'b1);
    frame(1'b1, 1'b1, 1'b1);

    run_to(143); probe("hit_below", LANE_X, m_y + 16);
    run_to(144); probe("hit_at_min", LANE_X, m_y + 16);
    run_to(299); probe("s1_right_in", LANE_X + 14, m_y + 16);
    run_to(300);
    probe("s2_left_out", LANE_X - 33, m_y + 32);
    probe("s2_left_in", LANE_X - 30, m_y + 32);
    probe("s2_right_in", LANE_X + 29, m_y + 32);
    probe("s2_right_out", LANE_X + 32, m_y + 32);
    probe("s2_bottom_in", LANE_X, m_y + 61);
    probe("s2_bottom_out", LANE_X, m_y + 64);
    run_to(450);
    probe("s4_left_out", LANE_X - 65, m_y + 64);
    probe("s4_left_in", LANE_X - 60, m_y + 64);
    probe("s4_right_in", LANE_X + 59, m_y + 64);
    probe("s4_bottom_in", LANE_X, m_y + 123);
    probe("s4_bottom_out", LANE_X, m_y + 128);
    probe("s4_above_out", LANE_X, m_y - 1);

    run_to(591);
    frame(1'b1, 1'b1, 1'b0);
    chk("end_state_resp", m_state, 2);
    probe("resp_dark", LANE_X, m_y + 64);
    frame(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < RESP; i++) frame(1'b1, 1'b1, 1'b0);
    chk("respawn_y", dut.sprite_y_q, 16'(Y_START));

    run_to(200);
    frame(1'b1, 1'b1, 1'b1);
    chk("collect_y", dut.sprite_y_q, 16'd200);
    probe("collect_dark", LANE_X, 216);
    for (int i = 0; i < RESP - 1; i++) frame(1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    frame(1'b1, 1'b1, 1'b0);

    run_to(350);
    probe("pre_reset_vis", LANE_X, m_y + 32);
    rst = 1'b1;
    #1;
    m_state = 0; m_y = Y_START; m_cnt = 0;
    chk("mid_rst_active", o_active, 1'b0);
    chk("mid_rst_outs", {o_red, o_green, o_blue, o_visible, o_hit, o_missed}, 27'h0);
    chk("mid_rst_y", dut.sprite_y_q, 16'(Y_START));
    @(posedge clk); #1;
    chk("mid_rst_missed", o_missed, 1'b0);
    rst = 1'b0;
    frame(1'b0, 1'b1, 1'b0);
    frame(1'b1, 1'b1, 1'b0);
    probe("after_rst_pix", LANE_X - 4, m_y + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
